// File: rtl/cnt_pkg.sv
// Shared definitions for the modulo-N counter: count direction encoding and
// legal ranges for the WIDTH/MODULUS parameters.
package cnt_pkg;

  typedef enum logic {
    CNT_DIR_DN = 1'b0,
    CNT_DIR_UP = 1'b1
  } cnt_dir_e;

  localparam int CNT_WIDTH_MIN   = 2;
  localparam int CNT_WIDTH_MAX   = 16;
  localparam int CNT_MODULUS_MIN = 2;

  function automatic int cnt_modulus_max(input int width);
    return 1 << width;
  endfunction

  function automatic bit cnt_params_legal(input int width, input int modulus);
    return (width >= CNT_WIDTH_MIN) && (width <= CNT_WIDTH_MAX) &&
           (modulus >= CNT_MODULUS_MIN) && (modulus <= cnt_modulus_max(width));
  endfunction

endpackage

// File: rtl/cnt_tc_decode.sv
// Terminal-value decode: flags the last count value in the selected direction
// (MODULUS-1 counting up, 0 counting down). Shared by TC and the wrap logic.
module cnt_tc_decode
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 120
) (
  input  logic [WIDTH-1:0] q,
  input  cnt_dir_e         dir,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

  assign at_term = (dir == CNT_DIR_UP) ? (q == Q_MAX) : (q == '0);

endmodule

// File: rtl/cnt_mod_param.sv
// Loadable modulo-MODULUS counter with cascadable terminal count and wrap pulse.
// Define CNT_UPDOWN_EN to honour UD; otherwise the counter counts up only.
module cnt_mod_param
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 120
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             CEP,
  input  logic             CET,
  input  logic             PE,
  input  logic             UD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  if (!cnt_params_legal(WIDTH, MODULUS)) begin : g_bad_params
    $error("cnt_mod_param: WIDTH=%0d MODULUS=%0d out of legal range", WIDTH, MODULUS);
  end

  // MODULUS-1 always fits in WIDTH bits, so the clamp compare never overflows.
  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_d, q_q;
  logic             wrap_d, wrap_q;
  logic             at_term;
  cnt_dir_e         dir;

`ifdef CNT_UPDOWN_EN
  assign dir = cnt_dir_e'(UD);
`else
  logic ud_unused;
  assign ud_unused = UD;
  assign dir       = CNT_DIR_UP;
`endif

  cnt_tc_decode #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_tc_decode (
    .q      (q_q),
    .dir    (dir),
    .at_term(at_term)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!PE) begin
      q_d = (D > Q_MAX) ? Q_MAX : D;
    end else if (CEP && CET) begin
      wrap_d = at_term;
      if (dir == CNT_DIR_UP) begin
        q_d = at_term ? '0 : q_q + WIDTH'(1);
      end else begin
        q_d = at_term ? Q_MAX : q_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge MR) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (MR) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign TC   = CET & at_term;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_cnt_mod_param.sv
// Scoreboard bench for cnt_mod_param: stimulus pushes expected post-edge values,
// a monitor pops and compares after each rising edge. Covers both UD builds.
module tb_cnt_mod_param;

  logic       Clk = 1'b0;
  logic       MR  = 1'b1;
  logic       CEP = 1'b0;
  logic       CET = 1'b0;
  logic       PE  = 1'b1;
  logic       UD  = 1'b1;
  logic [7:0] D   = 8'd0;
  logic [7:0] Q;
  logic       TC, WRAP;

  logic       bcd_en = 1'b0;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

  typedef struct {
    string      name;
    logic       is_bcd;
    logic [7:0] q;
    logic       tc;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 Clk = ~Clk;

  cnt_mod_param dut (
    .Clk(Clk), .MR(MR), .CEP(CEP), .CET(CET), .PE(PE), .UD(UD),
    .D(D), .Q(Q), .TC(TC), .WRAP(WRAP)
  );

  cnt_mod_param #(.WIDTH(4), .MODULUS(10)) u_lo (
    .Clk(Clk), .MR(MR), .CEP(bcd_en), .CET(bcd_en), .PE(1'b1), .UD(1'b1),
    .D(4'd0), .Q(lo_q), .TC(lo_tc), .WRAP(lo_wrap)
  );

  cnt_mod_param #(.WIDTH(4), .MODULUS(10)) u_hi (
    .Clk(Clk), .MR(MR), .CEP(bcd_en), .CET(lo_tc), .PE(1'b1), .UD(1'b1),
    .D(4'd0), .Q(hi_q), .TC(hi_tc), .WRAP(hi_wrap)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: one scoreboard entry per rising edge that the stimulus chose to check.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.is_bcd) begin
          check({e.name, ".bcd"}, {hi_q, lo_q}, e.q);
        end else begin
          check({e.name, ".q"}, Q, e.q);
          check({e.name, ".tc"}, {7'd0, TC}, {7'd0, e.tc});
          check({e.name, ".wrap"}, {7'd0, WRAP}, {7'd0, e.wrap});
        end
      end
    end
  end

  // Drive one edge's inputs, queue its expected result, advance to the next negedge.
  task automatic step(input string name, input logic cep, input logic cet,
                      input logic pe, input logic ud, input logic [7:0] d,
                      input logic [7:0] eq, input logic etc, input logic ewrap);
    exp_t e;
    CEP = cep; CET = cet; PE = pe; UD = ud; D = d;
    e.name = name; e.is_bcd = 1'b0; e.q = eq; e.tc = etc; e.wrap = ewrap;
    sb.push_back(e);
    @(negedge Clk);
  endtask

  initial begin
    exp_t e;
    logic [7:0] eq;

    // Reset state while MR is held, with UD=0 and CET=1.
    UD = 1'b0; CET = 1'b1;
    #2;
    check("rst.q", Q, 8'd0);
    check("rst.wrap", {7'd0, WRAP}, 8'd0);
`ifdef CNT_UPDOWN_EN
    check("rst.tc", {7'd0, TC}, 8'd1);
`else
    check("rst.tc", {7'd0, TC}, 8'd0);
`endif
    @(negedge Clk);
    MR = 1'b0;

    // Full up-count pass: 0..119, wrap to 0, then 1.
    for (int k = 1; k <= 121; k++) begin
      eq = 8'(k % 120);
      step($sformatf("up%0d", k), 1, 1, 1, 1, 8'd0, eq, eq == 8'd119, k == 120);
    end

    // Loads: clamp, in-range, ignore enables/direction, then hold cases.
    step("ld200",     1, 1, 0, 1, 8'd200, 8'd119, 1, 0);
    step("ld37",      1, 1, 0, 1, 8'd37,  8'd37,  0, 0);
    step("ld120",     0, 0, 0, 0, 8'd120, 8'd119, 0, 0);
    step("hold_cep0", 0, 1, 1, 1, 8'd0,   8'd119, 1, 0);
    step("hold_cet0", 1, 0, 1, 1, 8'd0,   8'd119, 0, 0);
    step("wrap_up",   1, 1, 1, 1, 8'd0,   8'd0,   0, 1);

`ifdef CNT_UPDOWN_EN
    step("dn_hold0",  0, 1, 1, 0, 8'd0,   8'd0,   1, 0);
    step("dn_wrap",   1, 1, 1, 0, 8'd0,   8'd119, 0, 1);
    step("dn118",     1, 1, 1, 0, 8'd0,   8'd118, 0, 0);
    step("ud_flip",   1, 1, 1, 1, 8'd0,   8'd119, 1, 0);
    step("dn_cet0",   1, 0, 1, 0, 8'd0,   8'd119, 0, 0);
    step("ld0",       1, 1, 0, 0, 8'd0,   8'd0,   1, 0);
`else
    step("ud0_hold",  0, 1, 1, 0, 8'd0,   8'd0,   0, 0);
    step("ud0_up1",   1, 1, 1, 0, 8'd0,   8'd1,   0, 0);
    step("ld118",     1, 1, 0, 0, 8'd118, 8'd118, 0, 0);
    step("ud0_119",   1, 1, 1, 0, 8'd0,   8'd119, 1, 0);
    step("ud0_wrap",  1, 1, 1, 0, 8'd0,   8'd0,   0, 1);
`endif

    // Asynchronous reset mid-cycle from Q=55, then load held off by MR.
    step("ld55", 1, 1, 0, 1, 8'd55, 8'd55, 0, 0);
    PE = 1'b1;
    #1 MR = 1'b1;
    #1 check("mr_async.q", Q, 8'd0);
    @(negedge Clk);
    step("mr_ld",     1, 1, 0, 1, 8'd37, 8'd0,  0, 0);
    MR = 1'b0;
    step("post_mr",   1, 1, 0, 1, 8'd37, 8'd37, 0, 0);
    step("post_mr_c", 1, 1, 1, 1, 8'd0,  8'd38, 0, 0);

    // WRAP cleared immediately by MR.
    step("ld119",  1, 1, 0, 1, 8'd119, 8'd119, 1, 0);
    step("wrap_b", 1, 1, 1, 1, 8'd0,   8'd0,   0, 1);
    #1 MR = 1'b1;
    #1 check("mr_async.wrap", {7'd0, WRAP}, 8'd0);
    @(negedge Clk);
    MR = 1'b0;

    // Cascaded BCD pair: 00..99, then 00, 01.
    CEP = 1'b0; PE = 1'b1;
    bcd_en = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      e.name = $sformatf("bcd%0d", k);
      e.is_bcd = 1'b1;
      e.q = {4'((k % 100) / 10), 4'(k % 10)};
      e.tc = 1'b0; e.wrap = 1'b0;
      sb.push_back(e);
      @(negedge Clk);
    end
    bcd_en = 1'b0;

    @(negedge Clk);
    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnt_mod_param.md
CNT_MOD_PARAM -- requirements
Module: cnt_mod_param

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter width in bits (legal range 2..16).
REQ-002 Parameter MODULUS, default 120, SHALL set the count length so that Q spans 0..MODULUS-1 (legal range 2..2**WIDTH).
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 MR  input  1  SHALL be the master reset, asynchronous, active-high.
REQ-005 CEP  input  1  SHALL be the parallel count enable.
REQ-006 CET  input  1  SHALL be the trickle count enable, also gating TC.
REQ-007 PE  input  1  SHALL be the active-low synchronous parallel load enable.
REQ-008 UD  input  1  SHALL select count direction: 1 = up, 0 = down.
REQ-009 D  input  WIDTH  SHALL be the parallel load data.
REQ-010 Q  output  WIDTH  SHALL be the registered count value.
REQ-011 TC  output  1  SHALL be the combinational terminal count for cascading.
REQ-012 WRAP  output  1  SHALL be a registered one-cycle pulse marking a wrap-around.

Function
REQ-013 Priority SHALL be MR > load (PE=0) > count (CEP & CET & PE) > hold.
REQ-014 Load: Q SHALL take D on the next edge; if D >= MODULUS, Q SHALL take MODULUS-1 (saturating clamp).
REQ-015 Load SHALL ignore CEP, CET and UD.
REQ-016 Count up: Q SHALL become Q+1, or 0 when Q == MODULUS-1.
REQ-017 Count down: Q SHALL become Q-1, or MODULUS-1 when Q == 0.
REQ-018 Hold: with CEP=0 or CET=0 and PE=1, Q SHALL be unchanged.
REQ-019 TC SHALL equal CET & (UD ? Q == MODULUS-1 : Q == 0), independent of CEP and PE.
REQ-020 WRAP SHALL be 1 for exactly the cycle after a count step that performed the wrap in REQ-016/017; 0 otherwise, including after loads.
REQ-021 Arithmetic SHALL be WIDTH bits wide with no intermediate overflow; when MODULUS = 2**WIDTH, the wrap SHALL coincide with natural roll-over.
REQ-022 A UD change SHALL take effect on the next count edge, with no extra latency.

Reset
REQ-023 MR=1 SHALL force Q=0 and WRAP=0 immediately, regardless of Clk.
REQ-024 TC after reset SHALL be CET & ~UD (Q == 0).
REQ-025 MR asserted mid-count SHALL abort the step; the first edge after MR deasserts SHALL apply normal priority.

Configuration
REQ-026 Macro CNT_UPDOWN_EN defined: UD SHALL behave as in REQ-008/016/017/019.
REQ-027 Macro CNT_UPDOWN_EN undefined: UD port SHALL remain but be ignored; the counter SHALL count up only, and TC SHALL decode MODULUS-1 only.

Structure
REQ-028 Shared package cnt_pkg SHALL hold the direction constants (CNT_DIR_UP=1, CNT_DIR_DN=0) and the WIDTH/MODULUS legal-range limits.
REQ-029 Sub-module cnt_tc_decode SHALL compute the terminal-value compare used by both TC and the wrap logic.
REQ-030 Illegal parameter combinations SHALL fail at elaboration.

Verification
REQ-031 Defaults, MR pulse, then CEP=CET=PE=1, UD=1 for 121 edges -> Q runs 0..119,0; TC=1 while Q=119; WRAP=1 at the cycle Q=0 (second pass).
REQ-032 PE=0, D=8'd200 -> Q=119 next edge; PE=0, D=8'd37 -> Q=37; WRAP stays 0 in both cases.
REQ-033 UD=0 from Q=0, count 1 edge -> Q=119, WRAP=1; TC=CET while Q=0; with CET=0, TC=0 and Q holds.
REQ-034 MR asserted between edges while Q=55 -> Q=0 immediately with no clock; PE=0 together with MR=1 -> Q stays 0.
REQ-035 Two instances cascaded (upper CET = lower TC, WIDTH=4, MODULUS=10) -> 100 edges give a BCD 00..99 sequence then wrap to 00.
REQ-036 Build without CNT_UPDOWN_EN, UD=0 held -> counter still counts up 0..119; TC decodes only Q=119.
